// File: rtl/hit_tracker_pkg.sv
// Shared types and default constants for the sprite hit tracker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hit_tracker_pkg;

    // Game-state FSM for one wave of aliens.
    typedef enum logic [1:0] {
        ST_PLAY       = 2'd0,
        ST_CLEAR_HOLD = 2'd1,
        ST_REARM      = 2'd2
    } hit_state_e;

    localparam int DEF_NUM_ALIENS        = 5;
    localparam int DEF_NUM_MISSILES      = 8;
    localparam int DEF_SCORE_W           = 16;
    localparam int DEF_POINTS_PER_ALIEN  = 10;
    localparam int DEF_CLEAR_HOLD_FRAMES = 60;

    // Extra headroom bits used when adding kill points before clamping.
    localparam int SCORE_GUARD_W = 4;

endpackage

// File: rtl/sprite_hit_tracker_popcount.sv
// Counts the set bits of a vector (used to count aliens killed per frame).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input.
module popcount #(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  vec_i,
    output logic [CW-1:0] cnt_o
);

    // Ripple-sum of every input bit; widths here are tiny.
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < W; i++) begin
            cnt_o = cnt_o + CW'(vec_i[i]);
        end
    end

endmodule

// File: rtl/sprite_hit_tracker.sv
// Missile-on-alien collision tracker: accumulates hits per frame, commits alive/score at frame_end.
// Latency: detection feeds pending state next cycle; commit outputs valid one cycle after frame_end.
// Backpressure: none; samples sprite flags every pixel clock, outputs are single-cycle pulses or levels.
module sprite_hit_tracker
    import hit_tracker_pkg::*;
#(
    parameter int NUM_ALIENS        = DEF_NUM_ALIENS,
    parameter int NUM_MISSILES      = DEF_NUM_MISSILES,
    parameter int SCORE_W           = DEF_SCORE_W,
    parameter int POINTS_PER_ALIEN  = DEF_POINTS_PER_ALIEN,
    parameter int CLEAR_HOLD_FRAMES = DEF_CLEAR_HOLD_FRAMES
) (
    input  logic                    vga_clk_i,
    input  logic                    vga_rst_i,
    input  logic                    video_on,
    input  logic                    frame_end,
    input  logic [NUM_ALIENS-1:0]   alien_active,
    input  logic [NUM_MISSILES-1:0] missile_active,
    output logic [NUM_ALIENS-1:0]   alien_alive,
    output logic [NUM_MISSILES-1:0] missile_retire,
    output logic                    hit_pulse,
    output logic [SCORE_W-1:0]      score,
    output logic                    wave_clear
);

    localparam int CNT_W = $clog2(NUM_ALIENS + 1);
    localparam int SUM_W = SCORE_W + SCORE_GUARD_W;
    localparam int FR_W  = (CLEAR_HOLD_FRAMES < 2) ? 1 : $clog2(CLEAR_HOLD_FRAMES + 1);

    localparam logic [SUM_W-1:0] POINTS_EXT    = SUM_W'(POINTS_PER_ALIEN);
    localparam logic [SUM_W-1:0] SCORE_MAX_EXT = {{SCORE_GUARD_W{1'b0}}, {SCORE_W{1'b1}}};
    localparam logic [FR_W-1:0]  LAST_FRAME    = FR_W'(CLEAR_HOLD_FRAMES - 1);

    hit_state_e                state_q, state_d;
    logic [NUM_ALIENS-1:0]     alive_q, alive_d;
    logic [SCORE_W-1:0]        score_q, score_d;
    logic [NUM_ALIENS-1:0]     pend_kill_q, pend_kill_d;
    logic [NUM_MISSILES-1:0]   pend_retire_q, pend_retire_d;
    logic [NUM_MISSILES-1:0]   retire_q, retire_d;
    logic                      hit_q, hit_d;
    logic                      wave_clear_q, wave_clear_d;
    logic [FR_W-1:0]           frames_q, frames_d;

    logic [NUM_ALIENS-1:0]     a_hit;
    logic                      det_on;
    logic [NUM_ALIENS-1:0]     det_kill;
    logic [NUM_MISSILES-1:0]   det_retire;
    logic [NUM_ALIENS-1:0]     kill_all;
    logic [NUM_MISSILES-1:0]   retire_all;
    logic [NUM_ALIENS-1:0]     alive_after;
    logic [CNT_W-1:0]          kill_cnt;
    logic [SUM_W-1:0]          score_sum;

    // The current pixel's hits are folded in so a frame_end cycle still counts.
    popcount #(
        .W  (NUM_ALIENS),
        .CW (CNT_W)
    ) u_kill_count (
        .vec_i (kill_all),
        .cnt_o (kill_cnt)
    );

    // Detection, frame commit and wave FSM next-state logic.
    always_comb begin
        state_d       = state_q;
        alive_d       = alive_q;
        score_d       = score_q;
        pend_kill_d   = pend_kill_q;
        pend_retire_d = pend_retire_q;
        retire_d      = '0;
        hit_d         = 1'b0;
        wave_clear_d  = wave_clear_q;
        frames_d      = frames_q;

        // Dead aliens are masked out, so missiles crossing them neither score nor retire.
        a_hit      = alien_active & alive_q;
        det_on     = (state_q == ST_PLAY) && video_on;
        det_kill   = (det_on && (|missile_active)) ? a_hit : '0;
        det_retire = (det_on && (|a_hit)) ? missile_active : '0;
        kill_all   = pend_kill_q | det_kill;
        retire_all = pend_retire_q | det_retire;
        alive_after = alive_q & ~kill_all;

        // Widened sum leaves headroom so the clamp sees the true total.
        score_sum = {{SCORE_GUARD_W{1'b0}}, score_q} + POINTS_EXT * SUM_W'(kill_cnt);

        case (state_q)
            ST_PLAY: begin
                pend_kill_d   = kill_all;
                pend_retire_d = retire_all;
                if (frame_end) begin
                    alive_d       = alive_after;
                    score_d       = (score_sum > SCORE_MAX_EXT) ? {SCORE_W{1'b1}}
                                                                : score_sum[SCORE_W-1:0];
                    retire_d      = retire_all;
                    hit_d         = |kill_all;
                    pend_kill_d   = '0;
                    pend_retire_d = '0;
                    if (alive_after == '0) begin
                        state_d      = ST_CLEAR_HOLD;
                        frames_d     = '0;
                        wave_clear_d = 1'b1;
                    end
                end
            end
            ST_CLEAR_HOLD: begin
                pend_kill_d   = '0;
                pend_retire_d = '0;
                if (frame_end) begin
                    if (frames_q == LAST_FRAME) begin
                        state_d = ST_REARM;
                    end else begin
                        frames_d = frames_q + FR_W'(1);
                    end
                end
            end
            ST_REARM: begin
                // Single cycle; any frame_end here is deliberately ignored.
                alive_d       = '1;
                wave_clear_d  = 1'b0;
                pend_kill_d   = '0;
                pend_retire_d = '0;
                state_d       = ST_PLAY;
            end
            default: begin
                state_d = ST_PLAY;
            end
        endcase
    end

    // State registers; reset discards pending hits and restarts in PLAY.
    always_ff @(posedge vga_clk_i) begin
        if (vga_rst_i) begin
            state_q       <= ST_PLAY;
            alive_q       <= '1;
            score_q       <= '0;
            pend_kill_q   <= '0;
            pend_retire_q <= '0;
            retire_q      <= '0;
            hit_q         <= 1'b0;
            wave_clear_q  <= 1'b0;
            frames_q      <= '0;
        end else begin
            state_q       <= state_d;
            alive_q       <= alive_d;
            score_q       <= score_d;
            pend_kill_q   <= pend_kill_d;
            pend_retire_q <= pend_retire_d;
            retire_q      <= retire_d;
            hit_q         <= hit_d;
            wave_clear_q  <= wave_clear_d;
            frames_q      <= frames_d;
        end
    end

    assign alien_alive    = alive_q;
    assign missile_retire = retire_q;
    assign hit_pulse      = hit_q;
    assign score          = score_q;
    assign wave_clear     = wave_clear_q;

endmodule

// File: tb/tb_sprite_hit_tracker.sv
// Directed self-checking bench for sprite_hit_tracker (SCORE_W=6, CLEAR_HOLD_FRAMES=3).
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: n/a.
module tb_sprite_hit_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       video_on;
    logic       frame_end;
    logic [4:0] alien_active;
    logic [7:0] missile_active;
    logic [4:0] alien_alive;
    logic [7:0] missile_retire;
    logic       hit_pulse;
    logic [5:0] score;
    logic       wave_clear;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sprite_hit_tracker #(
        .NUM_ALIENS        (5),
        .NUM_MISSILES      (8),
        .SCORE_W           (6),
        .POINTS_PER_ALIEN  (10),
        .CLEAR_HOLD_FRAMES (3)
    ) dut (
        .vga_clk_i      (clk),
        .vga_rst_i      (rst),
        .video_on       (video_on),
        .frame_end      (frame_end),
        .alien_active   (alien_active),
        .missile_active (missile_active),
        .alien_alive    (alien_alive),
        .missile_retire (missile_retire),
        .hit_pulse      (hit_pulse),
        .score          (score),
        .wave_clear     (wave_clear)
    );

    // Advance one clock; afterwards outputs reflect that edge and inputs may change.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic [4:0] a, input logic [7:0] m);
        video_on       = v;
        frame_end      = f;
        alien_active   = a;
        missile_active = m;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 5'b0, 8'h00);
    endtask

    // One frame_end pulse with no sprites present.
    task automatic frame();
        drive(1'b0, 1'b1, 5'b0, 8'h00);
        cyc();
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_alive", 32'(alien_alive), 32'h1F);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_wc", 32'(wave_clear), 32'd0);
        chk("rst_retire", 32'(missile_retire), 32'h00);
        chk("rst_hit", 32'(hit_pulse), 32'd0);

        // Single hit: alien 2 with missile 1.
        drive(1'b1, 1'b0, 5'b00100, 8'h02);
        cyc();
        idle();
        cyc();
        chk("pre_commit_alive", 32'(alien_alive), 32'h1F);
        chk("pre_commit_hit", 32'(hit_pulse), 32'd0);
        frame();
        chk("hit1_alive", 32'(alien_alive), 32'h1B);
        chk("hit1_score", 32'(score), 32'd10);
        chk("hit1_retire", 32'(missile_retire), 32'h02);
        chk("hit1_pulse", 32'(hit_pulse), 32'd1);
        cyc();
        chk("hit1_retire_off", 32'(missile_retire), 32'h00);
        chk("hit1_pulse_off", 32'(hit_pulse), 32'd0);

        // Dead alien 2 crossed, a missile on empty space, and an overlap during blanking.
        drive(1'b1, 1'b0, 5'b00100, 8'h01);
        cyc();
        drive(1'b1, 1'b0, 5'b00000, 8'h04);
        cyc();
        drive(1'b0, 1'b0, 5'b00001, 8'h01);
        cyc();
        frame();
        chk("miss_alive", 32'(alien_alive), 32'h1B);
        chk("miss_score", 32'(score), 32'd10);
        chk("miss_retire", 32'(missile_retire), 32'h00);
        chk("miss_hit", 32'(hit_pulse), 32'd0);

        // Two kills on separate pixels in one frame.
        drive(1'b1, 1'b0, 5'b00001, 8'h01);
        cyc();
        drive(1'b1, 1'b0, 5'b00010, 8'h10);
        cyc();
        frame();
        chk("dbl_alive", 32'(alien_alive), 32'h18);
        chk("dbl_score", 32'(score), 32'd30);
        chk("dbl_retire", 32'(missile_retire), 32'h11);

        // Overlapping last two aliens empties the wave.
        drive(1'b1, 1'b0, 5'b11000, 8'h04);
        cyc();
        frame();
        chk("last_alive", 32'(alien_alive), 32'h00);
        chk("last_score", 32'(score), 32'd50);
        chk("last_retire", 32'(missile_retire), 32'h04);
        chk("last_wc", 32'(wave_clear), 32'd1);

        // Hold: hits ignored; frame_end #1 carries a full overlap.
        drive(1'b1, 1'b1, 5'b11111, 8'hFF);
        cyc();
        idle();
        chk("hold_hit", 32'(hit_pulse), 32'd0);
        chk("hold_retire", 32'(missile_retire), 32'h00);
        chk("hold_score", 32'(score), 32'd50);
        chk("hold_wc1", 32'(wave_clear), 32'd1);
        frame();
        chk("hold_wc2", 32'(wave_clear), 32'd1);
        chk("hold_alive2", 32'(alien_alive), 32'h00);
        // Third frame_end (cycle u); frame_end held high into REARM is ignored.
        drive(1'b0, 1'b1, 5'b0, 8'h00);
        cyc();
        chk("rearm_alive_u1", 32'(alien_alive), 32'h00);
        cyc();
        idle();
        chk("rearm_alive_u2", 32'(alien_alive), 32'h1F);
        chk("rearm_wc_u2", 32'(wave_clear), 32'd0);
        chk("rearm_score", 32'(score), 32'd50);
        chk("rearm_hit", 32'(hit_pulse), 32'd0);

        // Wave 2: two kills from 50 clamp at 63.
        drive(1'b1, 1'b0, 5'b00011, 8'h08);
        cyc();
        frame();
        chk("sat_alive", 32'(alien_alive), 32'h1C);
        chk("sat_score", 32'(score), 32'd63);
        chk("sat_hit", 32'(hit_pulse), 32'd1);
        drive(1'b1, 1'b0, 5'b11100, 8'h20);
        cyc();
        frame();
        chk("sat2_score", 32'(score), 32'd63);
        chk("sat2_wc", 32'(wave_clear), 32'd1);
        frame();

        // Reset in the middle of hold.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mrst_alive", 32'(alien_alive), 32'h1F);
        chk("mrst_score", 32'(score), 32'd0);
        chk("mrst_wc", 32'(wave_clear), 32'd0);
        cyc();
        chk("mrst_wc_hold", 32'(wave_clear), 32'd0);

        // Hit on the frame_end cycle itself.
        drive(1'b1, 1'b1, 5'b00010, 8'h80);
        cyc();
        idle();
        chk("same_alive", 32'(alien_alive), 32'h1D);
        chk("same_score", 32'(score), 32'd10);
        chk("same_retire", 32'(missile_retire), 32'h80);
        chk("same_hit", 32'(hit_pulse), 32'd1);
        cyc();
        chk("same_hit_off", 32'(hit_pulse), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_hit_tracker.md
# sprite_hit_tracker

Tracks missile-on-alien collisions for the video pipeline and owns the alive/score state that the pixel compositor consumes. Runs on the pixel clock. Each cycle it samples the per-sprite active flags produced by the alien and player/missile sprite generators. It accumulates hits over a frame and commits them at the frame boundary, so the displayed image never changes mid-frame. Outputs:

- `alien_alive` gates alien pixels in the compositor.
- `missile_retire` tells the missile logic to drop missiles that struck.
- `score` and `wave_clear` are for the HUD and game control.

## Interface
Parameters:
- NUM_ALIENS, 5, number of alien sprites tracked
- NUM_MISSILES, 8, number of player missile sprites
- SCORE_W, 16, score counter width
- POINTS_PER_ALIEN, 10, score added per alien killed
- CLEAR_HOLD_FRAMES, 60, frames held in wave-clear before re-arming

Ports:
- vga_clk_i  in  1  pixel clock; single clock domain
- vga_rst_i  in  1  reset, synchronous, active-high
- video_on  in  1  high during the visible region (from the display timing generator)
- frame_end  in  1  one-cycle pulse once per frame, after the last visible pixel
- alien_active  in  NUM_ALIENS  bit i high when the current pixel lies inside alien i
- missile_active  in  NUM_MISSILES  bit j high when the current pixel lies inside missile j
- alien_alive  out  NUM_ALIENS  registered alive mask; reset all ones
- missile_retire  out  NUM_MISSILES  one-cycle pulse per missile that hit; reset 0
- hit_pulse  out  1  one-cycle pulse when at least one kill commits; reset 0
- score  out  SCORE_W  saturating score; reset 0
- wave_clear  out  1  high while in CLEAR_HOLD; reset 0

## Operation
- Per-cycle detection runs only in PLAY and only while video_on=1.
  - `a_hit = alien_active & alien_alive`.
  - `m_any = |missile_active`.
  - If m_any: `pend_kill |= a_hit`.
  - If |a_hit: `pend_retire |= missile_active`.
  - Overlapping sprites: every alive alien and every missile present at that pixel is marked.
- Dead aliens (alive bit 0) never register hits, and missiles passing over them are not retired.
- Commit happens on frame_end in PLAY. The cycle's own detection term is OR'd in before commit.
  - `alive <= alive & ~pend_kill`.
  - `score <= min(score + POINTS_PER_ALIEN*popcount(pend_kill), 2^SCORE_W-1)`. Compute the sum at SCORE_W+4 bits, then clamp.
  - `missile_retire <= pend_retire`.
  - `hit_pulse <= |pend_kill`.
  - Both pending registers clear.
- missile_retire and hit_pulse are 0 in every other cycle.
- FSM states:
  - PLAY → CLEAR_HOLD: at commit, when the new alive mask is all zero. Frame counter resets to 0; wave_clear goes high the next cycle.
  - CLEAR_HOLD: detection is disabled and pending registers stay 0. Each frame_end increments the counter. The frame_end that brings the count to CLEAR_HOLD_FRAMES moves to REARM.
  - REARM: lasts one cycle. alive set to all ones, wave_clear cleared, pending registers cleared, then → PLAY.
- score persists across waves; only reset clears it.
- Reset asserted mid-frame or mid-hold returns immediately to PLAY with all outputs at their reset values and pending state discarded.

## Timing
- Detection adds no latency: the input sample in cycle t contributes to the pending registers at t+1.
- Commit: frame_end sampled high in cycle t → alive, score, missile_retire, and hit_pulse are valid in t+1.
- wave_clear rises in cycle t+1 after the emptying commit.
- After the CLEAR_HOLD_FRAMES-th frame_end at cycle u: REARM occupies u+1; alive is all ones and wave_clear is 0 from u+2 onward.
- A frame_end during REARM is ignored.
- frame_end with video_on=1 in the same cycle is legal; that cycle's hits are included in the commit.

## Structure
- Package `hit_tracker_pkg`: state enum (PLAY, CLEAR_HOLD, REARM) and default parameter constants.
- Sub-module `popcount`, parameterised by width, counts kills.
- Everything else lives in one always_ff and one always_comb.

## Test plan
- Reset: hold vga_rst_i 2 cycles → alive=5'b11111, score=0, wave_clear=0, missile_retire=0.
- Single hit: one visible cycle with alien_active=5'b00100 and missile_active=8'h02, then frame_end → next cycle alive=5'b11011, score=10, missile_retire=8'h02 for exactly 1 cycle, hit_pulse=1. Before frame_end, alive stays unchanged.
- Miss, dead alien, blanking:
  - missile over alien 2 after it is dead → no score change, no retire.
  - Overlap with video_on=0 → no hit.
- Multi-kill and saturation: with SCORE_W=6 and score=50, kill 2 aliens in one frame → score=63.
- Wave cycle with CLEAR_HOLD_FRAMES=3:
  - Kill the last alien → wave_clear=1.
  - Hits ignored while wave_clear=1.
  - After the 3rd frame_end, plus 2 cycles → alive all ones, wave_clear=0.
- Reset mid-hold and same-cycle hit: reset during CLEAR_HOLD → PLAY, score=0. A hit on the frame_end cycle itself is committed in that frame.
